// File: rtl/sram_ctrl.sv
// sram_ctrl: turns single-beat valid/ready core requests into sequenced strobe cycles
// for an asynchronous SRAM with active-low ce/oe/we and a shared tristate data bus.
module sram_ctrl #(
    parameter int ADDR_WIDTH  = 16,
    parameter int DATA_WIDTH  = 16,
    parameter int WAIT_CYCLES = 2,
    parameter int TURN_CYCLES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_adr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [ADDR_WIDTH-1:0] sram_adr,
    inout  wire  [DATA_WIDTH-1:0] sram_data
);
    localparam int MAX_CYCLES = WAIT_CYCLES > TURN_CYCLES ? WAIT_CYCLES : TURN_CYCLES;
    localparam int CW = $clog2(MAX_CYCLES + 1);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, TURN} state_t;

    state_t                state;
    logic [CW-1:0]         cnt;
    logic                  write;
    logic                  drive;
    logic [DATA_WIDTH-1:0] dout;

    assign req_ready = state == IDLE;
    assign sram_data = drive ? dout : 'z;

    // The drive enable only ever changes together with ce_n edges, so it never overlaps oe_n low.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            cnt       <= '0;
            write     <= 1'b0;
            drive     <= 1'b0;
            dout      <= '0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
            sram_adr  <= '0;
        end else begin
            rsp_valid <= 1'b0;
            case (state)
                IDLE: if (req_valid) begin
                    state     <= SETUP;
                    write     <= req_write;
                    drive     <= req_write;
                    dout      <= req_wdata;
                    sram_adr  <= req_adr;
                    sram_ce_n <= 1'b0;
                end
                SETUP: begin
                    state     <= ACCESS;
                    cnt       <= CW'(WAIT_CYCLES);
                    sram_we_n <= !write;
                    sram_oe_n <= write;
                end
                ACCESS: if (cnt == CW'(1)) begin
                    sram_we_n <= 1'b1;
                    sram_oe_n <= 1'b1;
                    if (write) begin
                        state <= HOLD;
                    end else begin
                        state     <= TURN;
                        cnt       <= CW'(TURN_CYCLES);
                        sram_ce_n <= 1'b1;
                        rsp_valid <= 1'b1;
                        rsp_rdata <= sram_data;
                    end
                end else begin
                    cnt <= cnt - 1'b1;
                end
                HOLD: begin
                    state     <= IDLE;
                    sram_ce_n <= 1'b1;
                    drive     <= 1'b0;
                end
                TURN: if (cnt == CW'(1)) state <= IDLE;
                      else cnt <= cnt - 1'b1;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: three controllers (W/T = 2/1, 1/3, 4/1) each on a behavioural async SRAM,
// exercised by directed operations and a small random sweep against a reference memory.
module tb_sram_ctrl;
    logic            clk = 1'b0;
    logic            reset_n;
    logic [2:0]      valid;
    logic            write;
    logic [15:0]     adr, wdata;
    wire  [2:0]      ready, rsp_v, ce_n, oe_n, we_n, drv;
    wire  [2:0][15:0] rdata, sadr;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] model [3][256];
    logic [15:0] last_rd [3];
    logic [2:0][15:0] padr;

    always #5 clk = ~clk;

    function automatic int pw(input int i);
        return i == 0 ? 2 : i == 1 ? 1 : 4;
    endfunction

    function automatic int pt(input int i);
        return i == 1 ? 3 : 1;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_inst
        localparam int W = g == 0 ? 2 : g == 1 ? 1 : 4;
        localparam int T = g == 1 ? 3 : 1;
        wire  [15:0] sd;
        logic [15:0] mem [256];
        sram_ctrl #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .WAIT_CYCLES(W), .TURN_CYCLES(T)) u_dut (
            .clk(clk), .reset_n(reset_n),
            .req_valid(valid[g]), .req_ready(ready[g]), .req_write(write),
            .req_adr(adr), .req_wdata(wdata),
            .rsp_valid(rsp_v[g]), .rsp_rdata(rdata[g]),
            .sram_ce_n(ce_n[g]), .sram_oe_n(oe_n[g]), .sram_we_n(we_n[g]),
            .sram_adr(sadr[g]), .sram_data(sd)
        );
        assign drv[g] = u_dut.drive;
        initial for (int k = 0; k < 256; k++) mem[k] = 16'hC000 ^ 16'(k);
        assign sd = (!ce_n[g] && !oe_n[g] && we_n[g]) ? mem[sadr[g][7:0]] : 16'bz;
        always @(posedge we_n[g]) if (!ce_n[g]) mem[sadr[g][7:0]] <= sd;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Bus invariants: no drive under oe_n low, no oe_n/we_n overlap, no address change with we_n low.
    always @(negedge clk) begin
        for (int i = 0; i < 3; i++)
            check("invariant", {29'd0, drv[i] & ~oe_n[i], ~oe_n[i] & ~we_n[i],
                  ~we_n[i] & (sadr[i] != padr[i])}, 32'd0);
        padr = sadr;
    end

    task automatic do_op(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d,
                         output int occ, output int wew, output int oew, output int cew,
                         output int drn, output int rs, output int ra, output logic [15:0] rd);
        occ = 0; wew = 0; oew = 0; cew = 0; drn = 0; rs = 0; ra = 0;
        @(negedge clk);
        valid[i] = 1'b1; write = wr; adr = a; wdata = d;
        for (int n = 1; n <= 24; n++) begin
            @(negedge clk);
            valid[i] = 1'b0;
            if (ready[i]) break;
            occ++;
            if (!we_n[i]) wew++;
            if (!oe_n[i]) oew++;
            if (!ce_n[i]) cew++;
            if (drv[i]) drn++;
            if (rsp_v[i]) begin rs++; ra = n; end
        end
        rd = rdata[i];
    endtask

    task automatic op_check(input int i, input logic wr, input logic [15:0] a, input logic [15:0] d);
        int occ, wew, oew, cew, drn, rs, ra, w, t;
        logic [15:0] rd;
        w = pw(i);
        t = pt(i);
        do_op(i, wr, a, d, occ, wew, oew, cew, drn, rs, ra, rd);
        check("occupancy", occ, wr ? w + 2 : w + 1 + t);
        check("strobe_width", wr ? wew : oew, w);
        check("ce_width", cew, wr ? w + 2 : w + 1);
        check("drive_clks", drn, wr ? w + 2 : 0);
        check("rsp_count", rs, wr ? 0 : 1);
        if (wr) begin
            model[i][a[7:0]] = d;
            check("rdata_held", rd, last_rd[i]);
        end else begin
            check("rsp_at", ra, w + 2);
            check("rdata", rd, model[i][a[7:0]]);
            last_rd[i] = rd;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1);
    end

    initial begin
        int ce_lo, we_lo, oe_lo, rs, turn;
        for (int i = 0; i < 3; i++) begin
            last_rd[i] = '0;
            for (int k = 0; k < 256; k++) model[i][k] = 16'hC000 ^ 16'(k);
        end
        valid = '0; write = 1'b0; adr = '0; wdata = '0; reset_n = 1'b0;
        #7;
        check("rst_strobes", {ce_n, oe_n, we_n}, 9'h1FF);
        check("rst_drive_rsp", {drv, rsp_v}, 6'd0);
        @(negedge clk); @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("rst_ready", ready, 3'b111);
        check("rst_rdata", rdata, 48'd0);

        op_check(0, 1'b1, 16'h0005, 16'h1234);
        op_check(0, 1'b0, 16'h0005, 16'h0000);

        // read @5 then write @6 with valid held high across both
        ce_lo = 0; we_lo = 0; oe_lo = 0; rs = 0; turn = 0;
        @(negedge clk);
        valid[0] = 1'b1; write = 1'b0; adr = 16'h0005;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin write = 1'b1; adr = 16'h0006; wdata = 16'hBEEF; end
            if (n == 6) valid[0] = 1'b0;
            if (!ce_n[0]) ce_lo++;
            if (!we_n[0]) we_lo++;
            if (!oe_n[0]) oe_lo++;
            if (rsp_v[0]) rs++;
            if (!ready[0] && ce_n[0] && !drv[0]) turn++;
        end
        model[0][6] = 16'hBEEF;
        check("b2b_ce_low", ce_lo, 7);
        check("b2b_we_low", we_lo, 2);
        check("b2b_oe_low", oe_lo, 2);
        check("b2b_rsp", rs, 1);
        check("b2b_turn", turn, 1);
        check("b2b_rdata", rdata[0], 16'h1234);
        op_check(0, 1'b0, 16'h0006, 16'h0000);
        op_check(0, 1'b0, 16'h0005, 16'h0000);

        // async reset in the second ACCESS clock of a write
        @(negedge clk);
        valid[0] = 1'b1; write = 1'b1; adr = 16'h0008; wdata = 16'hDEAD;
        @(negedge clk);
        valid[0] = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        check("rst5_we_before", we_n[0], 1'b0);
        reset_n = 1'b0;
        #1;
        check("rst5_strobes", {ce_n[0], oe_n[0], we_n[0]}, 3'b111);
        check("rst5_drive", drv[0], 1'b0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) last_rd[i] = '0;
        op_check(0, 1'b0, 16'h0007, 16'h0000);
        check("rst5_preload", last_rd[0], 16'hC007);

        for (int i = 0; i < 3; i++)
            for (int n = 0; n < 86; n++)
                op_check(i, 1'($urandom_range(1)), 16'(16 + $urandom_range(15)), 16'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
